// File: rtl/trap_pending_queue_pkg.sv
// Shared types and constants for the pending-trap queue: FSM encoding,
// the "no trap" code and the parameter legality check.
package trap_pkg;

  typedef enum logic [1:0] {
    TQ_IDLE    = 2'd0,
    TQ_PRESENT = 2'd1,
    TQ_RETIRE  = 2'd2
  } tq_state_t;

  localparam int TT_NONE = 0;

  // tt = index+1 must fit in tt_w bits with 0 kept free for "none".
  function automatic bit tt_width_ok(input int num_src, input int tt_w);
    return (num_src >= 1) && (tt_w >= 1) && (tt_w < 31) &&
           (num_src <= (1 << tt_w) - 1);
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-first priority encoder; reports any-set and winning index+1.
module trap_prio_enc #(
  parameter int NUM_SRC = 6,
  parameter int TT_W    = 3
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_any,
  output logic [TT_W-1:0]    o_tt
);

  always_comb begin
    o_any = 1'b0;
    o_tt  = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_tt  = TT_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/trap_pending_queue.sv
// Sticky pending-trap collector with masked priority arbitration and a
// valid/ack presentation FSM feeding the trap type into TBR.
module trap_pending_queue
  import trap_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int TT_W    = 3
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [NUM_SRC-1:0] trap_req,
  input  logic [NUM_SRC-1:0] trap_mask,
  input  logic               ET,
  input  logic               flush,
  input  logic               trap_ack,
  output logic               trap_valid,
  output logic [TT_W-1:0]    tt,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  output logic               busy
);

  generate
    if (!tt_width_ok(NUM_SRC, TT_W)) begin : g_bad_params
      $error("trap_pending_queue: NUM_SRC must be <= 2**TT_W - 1");
    end
  endgenerate

  tq_state_t          r_state, w_state_nxt;
  logic [TT_W-1:0]    r_tt, w_tt_nxt;
  logic [NUM_SRC-1:0] r_pending, r_overrun;
  logic [NUM_SRC-1:0] w_elig, w_win_vec, w_clr_vec;
  logic [TT_W-1:0]    w_enc_tt;
  logic               w_any, w_ack_ok;

  assign w_elig = r_pending & trap_mask;

  trap_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .TT_W    (TT_W)
  ) u_prio_enc (
    .i_req (w_elig),
    .o_any (w_any),
    .o_tt  (w_enc_tt)
  );

  // The bit retired on ack comes from the frozen tt, not the live encoder,
  // so mask changes during presentation cannot redirect the clear.
  always_comb begin
    w_win_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_win_vec[i] = (r_tt == TT_W'(i + 1));
    end
  end

  assign w_ack_ok  = (r_state == TQ_PRESENT) && trap_ack;
  assign w_clr_vec = flush ? '1 : (w_ack_ok ? w_win_vec : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_tt_nxt    = r_tt;
    case (r_state)
      TQ_IDLE: begin
        if (flush) begin
          w_tt_nxt = TT_W'(TT_NONE);
        end else if (ET && w_any) begin
          w_state_nxt = TQ_PRESENT;
          w_tt_nxt    = w_enc_tt;
        end
      end
      TQ_PRESENT: begin
        if (flush) begin
          w_state_nxt = TQ_IDLE;
          w_tt_nxt    = TT_W'(TT_NONE);
        end else if (trap_ack) begin
          w_state_nxt = TQ_RETIRE;
        end
      end
      TQ_RETIRE: begin
        w_state_nxt = TQ_IDLE;
        w_tt_nxt    = TT_W'(TT_NONE);
      end
      default: begin
        w_state_nxt = TQ_IDLE;
        w_tt_nxt    = TT_W'(TT_NONE);
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state   <= TQ_IDLE;
      r_tt      <= TT_W'(TT_NONE);
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tt      <= w_tt_nxt;
      // A same-cycle request beats the clear so nothing is dropped.
      r_pending <= (r_pending & ~w_clr_vec) | trap_req;
      if (flush) begin
        r_overrun <= '0;
      end else begin
        r_overrun <= r_overrun | (trap_req & r_pending & ~w_clr_vec);
      end
    end
  end

  assign trap_valid = (r_state == TQ_PRESENT);
  assign busy       = (r_state != TQ_IDLE);
  assign tt         = r_tt;
  assign pending    = r_pending;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_trap_pending_queue.sv
// Vector-table and scoreboard bench for trap_pending_queue (NUM_SRC=6, TT_W=3).
module tb_trap_pending_queue;

  logic       Clk;
  logic       Clr;
  logic [5:0] trap_req;
  logic [5:0] trap_mask;
  logic       ET;
  logic       flush;
  logic       trap_ack;
  logic       trap_valid;
  logic [2:0] tt;
  logic [5:0] pending;
  logic [5:0] overrun;
  logic       busy;

  trap_pending_queue #(.NUM_SRC(6), .TT_W(3)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .trap_req   (trap_req),
    .trap_mask  (trap_mask),
    .ET         (ET),
    .flush      (flush),
    .trap_ack   (trap_ack),
    .trap_valid (trap_valid),
    .tt         (tt),
    .pending    (pending),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0] req;
    logic [5:0] mask;
    logic       et;
    logic       fl;
    logic       ack;
    logic       e_valid;
    logic [2:0] e_tt;
    logic [5:0] e_pend;
    logic [5:0] e_ovr;
    logic       e_busy;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];
  vec_t sb_q [$];

  int n_total  = 0;
  int n_passed = 0;

  function automatic vec_t mk(input logic [5:0] req, input logic [5:0] mask,
                              input logic et, input logic fl, input logic ack,
                              input logic ev, input logic [2:0] ett,
                              input logic [5:0] ep, input logic [5:0] eo,
                              input logic eb);
    vec_t v;
    v.req = req; v.mask = mask; v.et = et; v.fl = fl; v.ack = ack;
    v.e_valid = ev; v.e_tt = ett; v.e_pend = ep; v.e_ovr = eo; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int tag, input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, tag, act, exp);
  endtask

  task automatic check_all(input int tag, input vec_t e);
    chk("trap_valid", tag, {7'd0, trap_valid}, {7'd0, e.e_valid});
    chk("tt",         tag, {5'd0, tt},         {5'd0, e.e_tt});
    chk("pending",    tag, {2'd0, pending},    {2'd0, e.e_pend});
    chk("overrun",    tag, {2'd0, overrun},    {2'd0, e.e_ovr});
    chk("busy",       tag, {7'd0, busy},       {7'd0, e.e_busy});
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input int tag, input vec_t v);
    vec_t e;
    trap_req  = v.req;
    trap_mask = v.mask;
    ET        = v.et;
    flush     = v.fl;
    trap_ack  = v.ack;
    sb_q.push_back(v);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard [%0d]: queue empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_all(tag, e);
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(i, tbl[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_passed, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    // Two-edge request path, ack, next-winner after ack+2.
    tbl[0]  = mk(6'b100100, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b100100, 6'b0, 0);
    tbl[1]  = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd3, 6'b100100, 6'b0, 1);
    tbl[2]  = mk(6'b000000, 6'h3F, 1, 0, 1, 0, 3'd3, 6'b100000, 6'b0, 1);
    tbl[3]  = mk(6'b000000, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b100000, 6'b0, 0);
    tbl[4]  = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd6, 6'b100000, 6'b0, 1);
    tbl[5]  = mk(6'b000000, 6'h3F, 1, 0, 1, 0, 3'd6, 6'b000000, 6'b0, 1);
    tbl[6]  = mk(6'b000000, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b000000, 6'b0, 0);
    tbl[7]  = mk(6'b000001, 6'h3F, 0, 0, 0, 0, 3'd0, 6'b000001, 6'b0, 0);
    // ET rises with bit 0 pending, then request collides with its own ack.
    tbl[8]  = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd1, 6'b000001, 6'b0, 1);
    tbl[9]  = mk(6'b000001, 6'h3F, 1, 0, 1, 0, 3'd1, 6'b000001, 6'b0, 1);
    tbl[10] = mk(6'b000000, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b000001, 6'b0, 0);
    tbl[11] = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd1, 6'b000001, 6'b0, 1);
    tbl[12] = mk(6'b000000, 6'h3F, 1, 0, 1, 0, 3'd1, 6'b000000, 6'b0, 1);
    tbl[13] = mk(6'b000000, 6'h3F, 0, 0, 1, 0, 3'd0, 6'b000000, 6'b0, 0);
    // Overrun on repeated request to a pending source, cleared by flush.
    tbl[14] = mk(6'b000100, 6'h3F, 0, 0, 0, 0, 3'd0, 6'b000100, 6'b000000, 0);
    tbl[15] = mk(6'b000100, 6'h3F, 0, 0, 0, 0, 3'd0, 6'b000100, 6'b000100, 0);
    tbl[16] = mk(6'b000100, 6'h3F, 0, 0, 0, 0, 3'd0, 6'b000100, 6'b000100, 0);
    tbl[17] = mk(6'b000000, 6'h3F, 0, 1, 0, 0, 3'd0, 6'b000000, 6'b000000, 0);
    // Masking: winner bit 1, presentation frozen against mask/ET changes.
    tbl[18] = mk(6'b000011, 6'h3E, 1, 0, 0, 0, 3'd0, 6'b000011, 6'b0, 0);
    tbl[19] = mk(6'b000000, 6'h3E, 1, 0, 0, 1, 3'd2, 6'b000011, 6'b0, 1);
    tbl[20] = mk(6'b000000, 6'h3C, 1, 0, 0, 1, 3'd2, 6'b000011, 6'b0, 1);
    tbl[21] = mk(6'b000000, 6'h3C, 0, 0, 0, 1, 3'd2, 6'b000011, 6'b0, 1);
    tbl[22] = mk(6'b000000, 6'h3C, 1, 0, 1, 0, 3'd2, 6'b000001, 6'b0, 1);
    tbl[23] = mk(6'b000000, 6'h3C, 1, 0, 0, 0, 3'd0, 6'b000001, 6'b0, 0);
    tbl[24] = mk(6'b000000, 6'h3C, 1, 0, 1, 0, 3'd0, 6'b000001, 6'b0, 0);
    tbl[25] = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd1, 6'b000001, 6'b0, 1);
    // Flush beats ack in PRESENT; the same-cycle request survives.
    tbl[26] = mk(6'b010000, 6'h3F, 1, 1, 1, 0, 3'd0, 6'b010000, 6'b0, 0);
    tbl[27] = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd5, 6'b010000, 6'b0, 1);
    tbl[28] = mk(6'b000000, 6'h3F, 1, 0, 1, 0, 3'd5, 6'b000000, 6'b0, 1);
    tbl[29] = mk(6'b000100, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b000100, 6'b0, 0);
    tbl[30] = mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd3, 6'b000100, 6'b0, 1);
    tbl[31] = mk(6'b000100, 6'h3F, 1, 0, 0, 1, 3'd3, 6'b000100, 6'b000100, 1);

    z = mk(6'b0, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b0, 6'b0, 0);

    Clr = 1'b0; trap_req = '0; trap_mask = 6'h3F; ET = 1'b0;
    flush = 1'b0; trap_ack = 1'b0;
    @(posedge Clk); @(posedge Clk); #1;
    check_all(100, z);
    Clr = 1'b1;

    run_range(0, 7);
    for (int c = 0; c < 20; c++)
      step(200 + c, mk(6'b0, 6'h3F, 0, 0, 0, 0, 3'd0, 6'b000001, 6'b0, 0));
    run_range(8, NV - 1);

    // Asynchronous reset in PRESENT with tt=3: outputs drop without an edge.
    trap_req = '0; trap_ack = 1'b0; flush = 1'b0;
    #3;
    Clr = 1'b0;
    #1;
    check_all(300, z);
    @(posedge Clk); #1;
    check_all(301, z);
    Clr = 1'b1;
    for (int c = 0; c < 3; c++) step(310 + c, z);
    step(320, mk(6'b001000, 6'h3F, 1, 0, 0, 0, 3'd0, 6'b001000, 6'b0, 0));
    step(321, mk(6'b000000, 6'h3F, 1, 0, 0, 1, 3'd4, 6'b001000, 6'b0, 1));

    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/trap_pending_queue.md
# trap_pending_queue

Parametrised pending-trap queue and arbiter for the SPARC datapath. It replaces the fixed 6-bit trap queue register and its `tt_Aux` encoder. It collects sticky trap requests from `NUM_SRC` sources and gates them with PSR.ET and a per-source mask. It then presents the highest-priority trap type to the control unit through a valid/ack handshake, and the acknowledged `tt` is what gets written into TBR[6:4].

## Interface
Parameters:
- `NUM_SRC`, default 6: number of trap sources; index 0 has the highest priority.
- `TT_W`, default 3: width of `tt`. Must satisfy `NUM_SRC <= 2**TT_W - 1`; elaboration fails otherwise.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Clr`  in  1  reset. Asynchronous, active-low.
- `trap_req`  in  NUM_SRC  one-cycle set requests, one bit per source.
- `trap_mask`  in  NUM_SRC  1 = source eligible for arbitration.
- `ET`  in  1  PSR enable-traps bit.
- `flush`  in  1  synchronous clear of `pending` and `overrun`.
- `trap_ack`  in  1  control unit accepts the presented trap.
- `trap_valid`  out  1  a trap is presented; `tt` is stable while this is high.
- `tt`  out  TT_W  trap type = winning index + 1; 0 = none.
- `pending`  out  NUM_SRC  sticky pending bits.
- `overrun`  out  NUM_SRC  sticky flag per source: a request arrived while that source was already pending.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- Reset (Clr=0, asynchronous) sets `pending` = 0, `overrun` = 0, `trap_valid` = 0, `tt` = 0, `busy` = 0, state = IDLE. A reset asserted mid-handshake abandons the trap with no ack required.
- Pending update each edge: `pending <= (pending & ~clr_vec) | trap_req`.
  - `clr_vec` is the winner bit on ack, or all ones on `flush`.
  - A request always wins over a same-cycle clear, so no request is lost.
- Overrun: `overrun[i]` is set when `trap_req[i]` and `pending[i]` are both high and bit i is not being cleared that cycle. Only `flush` or reset clears it.
- Arbitration: winner = lowest index i with `pending[i] & trap_mask[i]`. This is combinational, in sub-module `trap_prio_enc`.
- FSM states:
  - IDLE: if `ET` and any eligible pending bit exists, register winner+1 into `tt` and go to PRESENT.
  - PRESENT: `trap_valid` = 1 and `tt` is frozen. Changes to `ET` or `trap_mask` in this state have no effect, because presentation is committed.
    - `trap_ack`=1: clear the winner's pending bit and go to RETIRE.
    - `flush`=1 (takes priority over ack): clear everything and go to IDLE.
  - RETIRE: lasts one cycle. `trap_valid` = 0 and `tt` holds its value. Unconditionally go to IDLE; this gives the controller one cycle to clear ET.
- `tt` returns to 0 on entering IDLE from RETIRE, or on flush.
- `trap_ack` outside PRESENT is ignored.

## Timing
- Request to valid:
  - `trap_req` at edge n sets `pending` at n.
  - If the FSM is in IDLE with ET=1, it enters PRESENT at n+1, so `trap_valid` is high after edge n+1.
  - If the bit is already pending and ET rises, `trap_valid` is high after the first edge that samples ET=1.
- Ack sampled at edge k:
  - `trap_valid` is low after k.
  - The pending bit is cleared at k.
  - The earliest next `trap_valid` is after edge k+2.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Structure
- Package `trap_pkg` holds:
  - state encoding constants `TQ_IDLE`, `TQ_PRESENT`, `TQ_RETIRE`;
  - `TT_NONE` = 0;
  - a helper function `tt_width_ok`.
- Sub-module `trap_prio_enc`, parametrised by `NUM_SRC` and `TT_W`, provides the lowest-index-first encoder. It outputs `any` and `idx+1`.
- Everything else stays in `trap_pending_queue`: pending/overrun registers and the FSM.

## Test plan
Use NUM_SRC=6 and TT_W=3 unless stated otherwise.
1. Assert Clr=0 while in PRESENT with tt=3 -> immediately `trap_valid`=0, `tt`=0, `pending`=0, `overrun`=0, `busy`=0; after release, no trap until a new request arrives.
2. ET=1, mask=6'b111111, pulse trap_req=6'b100100 -> `trap_valid`=1 and `tt`=3 one edge later; ack -> `pending`=6'b100000, then `tt`=6 presented two edges after the ack edge.
3. ET=0 with `pending`=6'b000001 -> `trap_valid` stays 0 for 20 cycles; raise ET -> `trap_valid`=1, `tt`=1 after the next edge.
4. Pulse trap_req bit 2 twice while bit 2 is pending -> `overrun`=6'b000100. Separately, req bit 0 in the same cycle as the ack of winner bit 0 -> `pending[0]` stays 1 and `overrun[0]`=0.
5. mask=6'b111110 with pending=6'b000011 -> `tt`=2; drop mask bit 1 during PRESENT -> `tt` stays 2 until ack.
6. Assert flush in PRESENT together with trap_req=6'b010000 and ack -> next cycle `trap_valid`=0, `pending`=6'b010000, `overrun`=0, state IDLE.
